// File: rtl/video_timing_pkg.sv
// Shared constants and types for the raster timing generator.
// Defaults describe SVGA 800x600@60 with a 40 MHz pixel clock.
package video_timing_pkg;

  // SVGA 800x600@60 horizontal timing, in pixels
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;

  // SVGA 800x600@60 vertical timing, in lines
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  // Both syncs are positive for this mode
  localparam bit SVGA_HS_POL = 1'b1;
  localparam bit SVGA_VS_POL = 1'b1;

  // Derived totals
  localparam int SVGA_H_TOTAL = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
  localparam int SVGA_V_TOTAL = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

  // Minimum counter widths for the default mode
  localparam int SVGA_H_CNT_W = $clog2(SVGA_H_TOTAL);
  localparam int SVGA_V_CNT_W = $clog2(SVGA_V_TOTAL);

  // Coordinate bus width; counters are kept at this width so they map
  // straight onto the coordinate outputs without extension logic
  localparam int COORD_W        = 16;
  localparam int MAX_PIPE_DELAY = 7;

  typedef logic [COORD_W-1:0] coord_t;

  // Bits carried through the re-timing delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  // Inclusive window test used for the sync decodes
  function automatic logic in_window(coord_t cnt, coord_t lo, coord_t hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bus: the generator drives coordinates, sync and strobes;
// the consumer supplies the pixel-clock enable.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic   en;
  coord_t o_x;
  coord_t o_y;
  logic   o_h_sync;
  logic   o_v_sync;
  logic   o_de;
  logic   o_line_start;
  logic   o_frame_start;
  logic [COORD_W-1:0] o_frame_cnt;
  logic   o_h_sync_d;
  logic   o_v_sync_d;
  logic   o_de_d;

  modport master (
    input  en,
    output o_x, o_y, o_h_sync, o_v_sync, o_de, o_line_start, o_frame_start,
    output o_frame_cnt, o_h_sync_d, o_v_sync_d, o_de_d
  );

  modport slave (
    output en,
    input  o_x, o_y, o_h_sync, o_v_sync, o_de, o_line_start, o_frame_start,
    input  o_frame_cnt, o_h_sync_d, o_v_sync_d, o_de_d
  );

endinterface

// File: rtl/video_timing_gen_sync_delay_line.sv
// Enabled shift register that re-times sync/data-enable to match the
// latency of the downstream pixel pipeline. DEPTH 0 is a plain wire.
module sync_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_reg [DEPTH];

    // Shift one stage per enabled cycle; reset flushes to inactive levels
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_reg[i] <= RST_VAL;
        end
      end else if (en) begin
        stage_reg[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_reg[i] <= stage_reg[i-1];
        end
      end
    end

    assign dout = stage_reg[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster scan generator: h/v counters, coordinate bus, sync, data-enable,
// line/frame strobes, completed-frame count and re-timed sync outputs.
// Outputs are registered decodes of the counters, so they trail the
// counters by one enabled cycle.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = SVGA_H_ACTIVE,
  parameter int H_FP       = SVGA_H_FP,
  parameter int H_SYNC     = SVGA_H_SYNC,
  parameter int H_BP       = SVGA_H_BP,
  parameter int V_ACTIVE   = SVGA_V_ACTIVE,
  parameter int V_FP       = SVGA_V_FP,
  parameter int V_SYNC     = SVGA_V_SYNC,
  parameter int V_BP       = SVGA_V_BP,
  parameter bit HS_POL     = SVGA_HS_POL,
  parameter bit VS_POL     = SVGA_VS_POL,
  parameter int PIPE_DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);

  // Region boundaries at coordinate width; sync windows are inclusive
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Syncs idle at their inactive level, data-enable idles low
  localparam sync_bits_t SYNC_RST = sync_bits_t'({~HS_POL, ~VS_POL, 1'b0});

  // Reject timing sets that would collapse a region or overflow the bus
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY ||
      H_CNT_W > COORD_W || V_CNT_W > COORD_W) begin : g_param_check
    $error("video_timing_gen: porch/sync widths must be >= 1 and PIPE_DELAY 0..7");
  end

  coord_t h_cnt_reg, h_cnt_next;
  coord_t v_cnt_reg, v_cnt_next;
  logic   frame_wrap;
  logic [COORD_W-1:0] frame_cnt_reg;

  sync_bits_t sync_dec;
  logic       line_start_dec;
  logic       frame_start_dec;

  coord_t     x_reg, y_reg;
  sync_bits_t sync_reg;
  sync_bits_t sync_d;
  logic       line_start_reg;
  logic       frame_start_reg;

  // Next counter values: v advances only on the h wrap
  always_comb begin
    h_cnt_next = h_cnt_reg + coord_t'(1);
    v_cnt_next = v_cnt_reg;
    frame_wrap = 1'b0;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      if (v_cnt_reg == V_LAST) begin
        v_cnt_next = '0;
        frame_wrap = 1'b1;
      end else begin
        v_cnt_next = v_cnt_reg + coord_t'(1);
      end
    end
  end

  // Decode sync, data-enable and strobes from the current counters;
  // v sync depends on v only, so its edges land on h == 0
  always_comb begin
    sync_dec.hs     = in_window(h_cnt_reg, HS_START, HS_END) ? HS_POL : ~HS_POL;
    sync_dec.vs     = in_window(v_cnt_reg, VS_START, VS_END) ? VS_POL : ~VS_POL;
    sync_dec.de     = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    line_start_dec  = (h_cnt_reg == '0);
    frame_start_dec = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  // Counter and frame-count state; the frame count bumps on the v wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      frame_cnt_reg <= '0;
    end else if (vid.en) begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
      if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  // Output registers; strobes drop while disabled so none is repeated
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      sync_reg        <= SYNC_RST;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (vid.en) begin
      x_reg           <= h_cnt_reg;
      y_reg           <= v_cnt_reg;
      sync_reg        <= sync_dec;
      line_start_reg  <= line_start_dec;
      frame_start_reg <= frame_start_dec;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   ($bits(sync_bits_t)),
    .RST_VAL (SYNC_RST)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (vid.en),
    .din  (sync_reg),
    .dout (sync_d)
  );

  assign vid.o_x           = x_reg;
  assign vid.o_y           = y_reg;
  assign vid.o_h_sync      = sync_reg.hs;
  assign vid.o_v_sync      = sync_reg.vs;
  assign vid.o_de          = sync_reg.de;
  assign vid.o_line_start  = line_start_reg;
  assign vid.o_frame_start = frame_start_reg;
  assign vid.o_frame_cnt   = frame_cnt_reg;
  assign vid.o_h_sync_d    = sync_d.hs;
  assign vid.o_v_sync_d    = sync_d.vs;
  assign vid.o_de_d        = sync_d.de;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default SVGA instance for reset, line timing, enable
// gating and the 2-deep delay line; a small inverted-polarity instance
// with PIPE_DELAY 0 for whole-frame, vsync and mid-frame reset checks.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int tests_run = 0;
  int tests_failed = 0;

  video_timing_gen_if vif ();
  video_timing_gen_if sif ();

  video_timing_gen u_dut (
    .clk (clk),
    .rst (rst),
    .vid (vif)
  );

  // Small mode: H 16+2+3+3 = 24, V 8+1+2+2 = 13, frame = 312 cycles
  video_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .HS_POL (1'b0), .VS_POL (1'b0), .PIPE_DELAY (0)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .vid (sif)
  );

  always #5 clk = ~clk;

  // Expected {hs, vs, de} for a counter position
  function automatic logic [2:0] exp_bits(int x, int y, int h_act, int hs_lo, int hs_hi,
                                          int v_act, int vs_lo, int vs_hi, bit hp, bit vp);
    logic hs, vs, de;
    hs = (x >= hs_lo && x <= hs_hi) ? hp : ~hp;
    vs = (y >= vs_lo && y <= vs_hi) ? vp : ~vp;
    de = (x < h_act) && (y < v_act);
    return {hs, vs, de};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    vif.en = 1'b1;
    sif.en = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (vif.o_h_sync !== 1'b0) begin tests_failed++; $display("FAIL reset_hs: got %b want 0", vif.o_h_sync); end
    tests_run++; if (vif.o_x !== 16'd0) begin tests_failed++; $display("FAIL reset_x: got %0d want 0", vif.o_x); end
    tests_run++; if (vif.o_de !== 1'b0) begin tests_failed++; $display("FAIL reset_de: got %b want 0", vif.o_de); end
    tests_run++; if (vif.o_frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs: got %b want 0", vif.o_frame_start); end
    tests_run++; if (vif.o_h_sync_d !== 1'b0) begin tests_failed++; $display("FAIL reset_hs_d: got %b want 0", vif.o_h_sync_d); end
    tests_run++; if (sif.o_h_sync !== 1'b1) begin tests_failed++; $display("FAIL reset_small_hs: got %b want 1", sif.o_h_sync); end
    tests_run++; if (sif.o_v_sync_d !== 1'b1) begin tests_failed++; $display("FAIL reset_small_vs_d: got %b want 1", sif.o_v_sync_d); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (vif.o_x !== 16'd0 || vif.o_y !== 16'd0) begin tests_failed++; $display("FAIL first_xy: got (%0d,%0d) want (0,0)", vif.o_x, vif.o_y); end
    tests_run++; if (vif.o_de !== 1'b1) begin tests_failed++; $display("FAIL first_de: got %b want 1", vif.o_de); end
    tests_run++; if (vif.o_line_start !== 1'b1) begin tests_failed++; $display("FAIL first_ls: got %b want 1", vif.o_line_start); end
    tests_run++; if (vif.o_frame_start !== 1'b1) begin tests_failed++; $display("FAIL first_fs: got %b want 1", vif.o_frame_start); end
    tests_run++; if (vif.o_frame_cnt !== 16'd0) begin tests_failed++; $display("FAIL first_fcnt: got %0d want 0", vif.o_frame_cnt); end
    tests_run++; if (vif.o_h_sync !== 1'b0) begin tests_failed++; $display("FAIL first_hs: got %b want 0", vif.o_h_sync); end
    tests_run++; if (sif.o_frame_start !== 1'b0 || sif.o_x !== 16'd0) begin tests_failed++; $display("FAIL hold_small: got fs=%b x=%0d want fs=0 x=0", sif.o_frame_start, sif.o_x); end
    $display("[TB] test_reset done");
  endtask

  // Enters at sample k=0 (x=0,y=0) and ends at k=1056 (x=0,y=1)
  task automatic test_one_line();
    int bad = 0, bad_k = -1, bad_d = 0;
    int hs_cnt = 0, hs_first = -1, hs_last = -1, de_fall = -1, ls_first = -1, ls_second = -1;
    int ex, ey;
    logic [2:0] e;
    logic [2:0] p1 = 3'b000;
    logic [2:0] p2 = 3'b000;
    for (int k = 0; k <= 1056; k++) begin
      if (k > 0) @(negedge clk);
      ex = k % 1056;
      ey = k / 1056;
      e = exp_bits(ex, ey, 800, 840, 967, 600, 601, 604, 1'b1, 1'b1);
      if (vif.o_x !== 16'(ex) || vif.o_y !== 16'(ey) || {vif.o_h_sync, vif.o_v_sync, vif.o_de} !== e ||
          vif.o_line_start !== (ex == 0) || vif.o_frame_start !== (k == 0)) begin
        bad++;
        if (bad_k < 0) bad_k = k;
      end
      if ({vif.o_h_sync_d, vif.o_v_sync_d, vif.o_de_d} !== p2) bad_d++;
      p2 = p1;
      p1 = e;
      if (vif.o_h_sync === 1'b1) begin hs_cnt++; if (hs_first < 0) hs_first = k; hs_last = k; end
      if (de_fall < 0 && k > 0 && vif.o_de === 1'b0) de_fall = k;
      if (vif.o_line_start === 1'b1) begin
        if (ls_first < 0) ls_first = k; else if (ls_second < 0) ls_second = k;
      end
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL line_scan: %0d bad cycles (first k=%0d) want 0", bad, bad_k); end
    tests_run++; if (bad_d != 0) begin tests_failed++; $display("FAIL line_delay2: %0d bad cycles want 0", bad_d); end
    tests_run++; if (hs_cnt != 128) begin tests_failed++; $display("FAIL hs_width: got %0d want 128", hs_cnt); end
    tests_run++; if (hs_first != 840 || hs_last != 967) begin tests_failed++; $display("FAIL hs_window: got %0d..%0d want 840..967", hs_first, hs_last); end
    tests_run++; if (de_fall != 800) begin tests_failed++; $display("FAIL de_fall: got x=%0d want 800", de_fall); end
    tests_run++; if (ls_second - ls_first != 1056) begin tests_failed++; $display("FAIL ls_period: got %0d want 1056", ls_second - ls_first); end
    $display("[TB] test_one_line done");
  endtask

  // Enters at (0,1); en alternates 0/1 each cycle for 2116 cycles
  task automatic test_en_toggle();
    int mx = 0, my = 1;
    int bad = 0, bad_c = -1, ls_pulses = 0, hs_en = 0;
    bit en_was;
    logic [2:0] e;
    logic [2:0] ed = 3'b000;
    logic [2:0] p1 = 3'b001;
    logic [2:0] p2 = 3'b000;
    for (int c = 0; c < 2116; c++) begin
      en_was = (c % 2 == 1);
      vif.en = en_was;
      @(negedge clk);
      if (en_was) begin
        mx++;
        if (mx == 1056) begin mx = 0; my++; end
        ed = p2;
        p2 = p1;
        p1 = exp_bits(mx, my, 800, 840, 967, 600, 601, 604, 1'b1, 1'b1);
      end
      e = exp_bits(mx, my, 800, 840, 967, 600, 601, 604, 1'b1, 1'b1);
      if (vif.o_x !== 16'(mx) || vif.o_y !== 16'(my) || {vif.o_h_sync, vif.o_v_sync, vif.o_de} !== e ||
          vif.o_line_start !== (en_was && mx == 0) || vif.o_frame_start !== 1'b0 ||
          {vif.o_h_sync_d, vif.o_v_sync_d, vif.o_de_d} !== ed) begin
        bad++;
        if (bad_c < 0) bad_c = c;
      end
      if (vif.o_line_start === 1'b1) ls_pulses++;
      if (en_was && vif.o_h_sync === 1'b1) hs_en++;
    end
    vif.en = 1'b1;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL en_scan: %0d bad cycles (first c=%0d) want 0", bad, bad_c); end
    tests_run++; if (ls_pulses != 1) begin tests_failed++; $display("FAIL en_ls_count: got %0d want 1", ls_pulses); end
    tests_run++; if (hs_en != 128) begin tests_failed++; $display("FAIL en_hs_width: got %0d want 128", hs_en); end
    $display("[TB] test_en_toggle done");
  endtask

  // Small instance leaves its reset hold here; samples n=0..624
  task automatic test_frame();
    int bad = 0, bad_n = -1, vs_asserts = 0;
    int as_x = -1, as_y = -1, rel_x = -1, rel_y = -1;
    int fs_first = -1, fs_second = -1, fcnt_second = -1;
    int ex, ey;
    logic [2:0] e;
    logic prev_vs = 1'b1;
    sif.en = 1'b1;
    for (int n = 0; n <= 624; n++) begin
      @(negedge clk);
      ex = n % 24;
      ey = (n / 24) % 13;
      e = exp_bits(ex, ey, 16, 18, 20, 8, 9, 10, 1'b0, 1'b0);
      if (sif.o_x !== 16'(ex) || sif.o_y !== 16'(ey) || {sif.o_h_sync, sif.o_v_sync, sif.o_de} !== e ||
          sif.o_line_start !== (ex == 0) || sif.o_frame_start !== (ex == 0 && ey == 0) ||
          sif.o_frame_cnt !== 16'((n + 1) / 312) || {sif.o_h_sync_d, sif.o_v_sync_d, sif.o_de_d} !== e) begin
        bad++;
        if (bad_n < 0) bad_n = n;
      end
      if (prev_vs === 1'b1 && sif.o_v_sync === 1'b0) begin
        vs_asserts++;
        if (as_x < 0) begin as_x = ex; as_y = ey; end
      end
      if (prev_vs === 1'b0 && sif.o_v_sync === 1'b1 && rel_x < 0) begin rel_x = ex; rel_y = ey; end
      prev_vs = sif.o_v_sync;
      if (sif.o_frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) begin fs_second = n; fcnt_second = int'(sif.o_frame_cnt); end
      end
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL frame_scan: %0d bad cycles (first n=%0d) want 0", bad, bad_n); end
    tests_run++; if (vs_asserts != 2) begin tests_failed++; $display("FAIL vs_edges: got %0d want 2", vs_asserts); end
    tests_run++; if (as_x != 0 || as_y != 9) begin tests_failed++; $display("FAIL vs_assert_pos: got (%0d,%0d) want (0,9)", as_x, as_y); end
    tests_run++; if (rel_x != 0 || rel_y != 11) begin tests_failed++; $display("FAIL vs_release_pos: got (%0d,%0d) want (0,11)", rel_x, rel_y); end
    tests_run++; if (fs_second - fs_first != 312) begin tests_failed++; $display("FAIL fs_period: got %0d want 312", fs_second - fs_first); end
    tests_run++; if (fcnt_second != 1) begin tests_failed++; $display("FAIL fcnt_after_frame: got %0d want 1", fcnt_second); end
    $display("[TB] test_frame done");
  endtask

  task automatic test_reset_mid_frame();
    repeat (130) @(negedge clk);
    tests_run++; if (sif.o_x !== 16'd10 || sif.o_y !== 16'd5) begin tests_failed++; $display("FAIL mid_pos: got (%0d,%0d) want (10,5)", sif.o_x, sif.o_y); end
    rst = 1'b1;
    sif.en = 1'b0;
    @(negedge clk);
    tests_run++; if (sif.o_x !== 16'd0 || sif.o_y !== 16'd0 || sif.o_de !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_xyde: got (%0d,%0d,%b) want (0,0,0)", sif.o_x, sif.o_y, sif.o_de); end
    tests_run++; if (sif.o_line_start !== 1'b0 || sif.o_frame_start !== 1'b0 || sif.o_frame_cnt !== 16'd0) begin tests_failed++; $display("FAIL mid_rst_strobes: got ls=%b fs=%b fcnt=%0d want 0/0/0", sif.o_line_start, sif.o_frame_start, sif.o_frame_cnt); end
    tests_run++; if ({sif.o_h_sync, sif.o_v_sync, sif.o_h_sync_d, sif.o_v_sync_d, sif.o_de_d} !== 5'b11110) begin tests_failed++; $display("FAIL mid_rst_sync: got %b want 11110", {sif.o_h_sync, sif.o_v_sync, sif.o_h_sync_d, sif.o_v_sync_d, sif.o_de_d}); end
    tests_run++; if (vif.o_x !== 16'd0 || vif.o_h_sync_d !== 1'b0 || vif.o_de_d !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_main: got x=%0d hs_d=%b de_d=%b want 0/0/0", vif.o_x, vif.o_h_sync_d, vif.o_de_d); end
    rst = 1'b0;
    sif.en = 1'b1;
    @(negedge clk);
    tests_run++; if (sif.o_x !== 16'd0 || sif.o_y !== 16'd0 || sif.o_frame_start !== 1'b1 || sif.o_de !== 1'b1) begin tests_failed++; $display("FAIL restart: got (%0d,%0d) fs=%b de=%b want (0,0) 1 1", sif.o_x, sif.o_y, sif.o_frame_start, sif.o_de); end
    tests_run++; if (vif.o_de !== 1'b1 || vif.o_de_d !== 1'b0) begin tests_failed++; $display("FAIL flush_1: got de=%b de_d=%b want 1 0", vif.o_de, vif.o_de_d); end
    @(negedge clk);
    tests_run++; if (vif.o_de_d !== 1'b0 || sif.o_x !== 16'd1) begin tests_failed++; $display("FAIL flush_2: got de_d=%b x=%0d want 0 1", vif.o_de_d, sif.o_x); end
    @(negedge clk);
    tests_run++; if (vif.o_de_d !== 1'b1) begin tests_failed++; $display("FAIL flush_3: got de_d=%b want 1", vif.o_de_d); end
    $display("[TB] test_reset_mid_frame done");
  endtask

  initial begin
    test_reset();
    test_one_line();
    test_en_toggle();
    test_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates the raster scan that drives the pixel pipeline: horizontal and vertical counters, the `x`/`y` coordinate bus, sync and data-enable, and frame and line strobes. It sits at the head of the display path and feeds the sprite compositor and the Mandelbrot pixel generator. A configurable delay line re-times sync and data-enable to match downstream pipeline latency. Defaults give 800x600@60 (40 MHz pixel clock).

## Interface

**Parameters**
- `H_ACTIVE`, default 800: visible pixels per line.
- `H_FP`, default 40: horizontal front porch, in pixels.
- `H_SYNC`, default 128: horizontal sync width, in pixels.
- `H_BP`, default 88: horizontal back porch, in pixels.
- `V_ACTIVE`, default 600: visible lines per frame.
- `V_FP`, default 1: vertical front porch, in lines.
- `V_SYNC`, default 4: vertical sync width, in lines.
- `V_BP`, default 23: vertical back porch, in lines.
- `HS_POL`, default 1: asserted level of `o_h_sync`.
- `VS_POL`, default 1: asserted level of `o_v_sync`.
- `PIPE_DELAY`, default 2: delay (0..7) of the `_d` outputs, in enabled cycles.

**Ports**
- `clk` in 1: pixel clock.
- `rst` in 1: reset rst, synchronous, active-high.
- `en` in 1: pixel-clock enable; when 0, all state holds.
- `o_x` out 16: horizontal counter, zero-extended.
- `o_y` out 16: vertical counter, zero-extended.
- `o_h_sync` out 1: horizontal sync.
- `o_v_sync` out 1: vertical sync.
- `o_de` out 1: high inside the active region.
- `o_line_start` out 1: 1-cycle pulse when `o_x`==0.
- `o_frame_start` out 1: 1-cycle pulse when `o_x`==0 and `o_y`==0.
- `o_frame_cnt` out 16: completed-frame counter; wraps.
- `o_h_sync_d` out 1: `o_h_sync` delayed by PIPE_DELAY enabled cycles.
- `o_v_sync_d` out 1: `o_v_sync` delayed by PIPE_DELAY enabled cycles.
- `o_de_d` out 1: `o_de` delayed by PIPE_DELAY enabled cycles.

## Operation

**Totals**
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 1056).
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 628).

**Region order on each axis:** active, front porch, sync, back porch, with active first.

**Counters**
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0.
- `v_cnt` advances only when `h_cnt` wraps; it counts 0..V_TOTAL-1 and wraps.
- Frame counter increments once per `v_cnt` wrap, in the same cycle as the wrap; it wraps 0xFFFF->0.

**Horizontal sync:** asserted (level HS_POL) for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Default range is 840..967.

**Vertical sync**
- Asserted (level VS_POL) for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Default range is 601..604.
- It is asserted over whole lines, with edges aligned to `h_cnt`==0.
- Exactly one asserted-going edge per frame; the compositor position update depends on this.

**Data enable:** `o_de` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).

**Coordinates in blanking:** `o_x` and `o_y` continue counting through blanking; consumers gate on `o_de`.

**Enable behaviour**
- When `en`=0, counters, outputs and the delay line hold.
- `o_line_start` and `o_frame_start` are forced to 0 while `en`=0, so no strobe is duplicated.

**Delay line**
- A shift register of depth PIPE_DELAY carries {hs, vs, de}.
- PIPE_DELAY=0 makes the `_d` outputs equal to the undelayed outputs.

## Timing

**Output registering**
- All outputs are registered.
- On each enabled edge the outputs load the decode of the current counter values while the counters advance.
- Outputs therefore lag the counters by one enabled cycle.

**Reset values**
- Counters, `o_x`, `o_y`, `o_de`, strobes, frame count and `o_de_d` reset to 0.
- Sync outputs and the delay-line sync bits reset to their inactive levels: ~HS_POL and ~VS_POL.

**First cycle after reset:** the first enabled edge after `rst` deasserts produces `o_x`=0, `o_y`=0, `o_de`=1, `o_line_start`=1, `o_frame_start`=1.

**Frame period:** H_TOTAL*V_TOTAL enabled cycles (default 663168) between successive `o_frame_start` pulses.

**Reset mid-frame**
- `rst` takes effect on the next edge regardless of `en`.
- All state returns to reset values, the delay line is flushed, and the scan restarts at (0,0).

**Line boundary:** last pixel of a line is `o_x`=H_TOTAL-1; the next enabled cycle shows `o_x`=0 and `o_y`+1, or `o_y`=0 when `o_y` was V_TOTAL-1.

## Structure

**Package `video_timing_pkg`**
- SVGA 800x600 constants: H/V active, porch and sync widths; polarity.
- Derived totals.
- Localparam counter widths via `$clog2`.

**Sub-module `sync_delay_line`**
- Parameter DEPTH (0..7), parameter WIDTH; clock, reset and enable inputs.
- Reset value supplied per bit.

**Elaboration checks:** the top instantiates one `sync_delay_line` with WIDTH 3 and elaborates a check that each porch and sync width is ≥1 and that PIPE_DELAY is ≤7.

## Test plan

All scenarios use default parameters unless stated.

1. Reset with `en`=1, release: 1 cycle later `o_x`=0, `o_y`=0, `o_de`=1, `o_frame_start`=1, `o_frame_cnt`=0; `o_h_sync`=0 during reset.
2. Run one line: `o_h_sync`=1 exactly while `o_x`=840..967 (128 cycles); `o_de`=0 from `o_x`=800; `o_line_start` period is 1056.
3. Run a full frame: `o_v_sync` rises when (`o_x`,`o_y`)=(0,601) and falls at (0,605); `o_frame_start` repeats after 663168 cycles, with `o_frame_cnt`=1.
4. Toggle `en` at 50% duty mid-line: coordinates advance only on enabled edges; no duplicated `o_line_start`; sync width stays 128 enabled cycles.
5. Assert `rst` at (`o_x`,`o_y`)=(400,300) for 1 cycle: next cycle all outputs are at reset values, and the scan restarts at (0,0).
6. PIPE_DELAY=2 and PIPE_DELAY=0: `o_h_sync_d`, `o_v_sync_d` and `o_de_d` equal the undelayed outputs shifted by 2 enabled cycles, and unshifted respectively.
